booth_mult_sched: RTL and testbench

Sequential radix-2 Booth multiply engine shared by NREQ requesters through a round-robin arbiter.
- Accepts one signed WIDTH x WIDTH job at a time and iterates one Booth step per clock.
- Returns the 2*WIDTH-bit signed product tagged with the requester index.
- Replaces per-requester combinational Booth multipliers where area matters more than latency.

---
 rtl/booth_mult_sched.sv | 194 +++++++++++++++++++
 tb/tb_booth_mult_sched.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_sched.sv
// booth_mult_sched
//   Sequential radix-2 Booth multiplier shared by NREQ requesters through a
//   round-robin arbiter. One signed WIDTH x WIDTH job is accepted at a time.
//   The engine iterates one Booth step per clock for WIDTH clocks. It then
//   holds the 2*WIDTH-bit product, tagged with the requester index, until the
//   consumer takes it.
//
// Optional feature macro: BOOTH_ZERO_BYPASS_EN
//   When defined, a job with a zero operand skips RUN and goes straight to
//   DONE with a zero product.
//
// Ports
//   clk           clock, all logic on the rising edge
//   rst           synchronous active-high reset
//   req_valid     [NREQ]         per-requester job valid
//   req_ready     [NREQ]         per-requester accept (one-hot or zero, IDLE only)
//   req_a         [NREQ*WIDTH]   multiplicands, requester i at [i*WIDTH +: WIDTH]
//   req_b         [NREQ*WIDTH]   multipliers, same packing
//   resp_valid    product valid (DONE state)
//   resp_ready    consumer accepts product
//   resp_id       [IDW]          requester owning the product
//   resp_product  [2*WIDTH]      signed product a*b
//   busy          high whenever the engine is not IDLE
module booth_mult_sched #(
  parameter  int WIDTH = 4,
  parameter  int NREQ  = 2,
  localparam int IDW   = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [IDW-1:0]          resp_id,
  output logic [2*WIDTH-1:0]      resp_product,
  output logic                    busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [WIDTH:0]       m_q, m_d;        // multiplicand with guard bit
  logic [WIDTH:0]       acc_q, acc_d;    // Booth A register with guard bit
  logic [WIDTH-1:0]     mq_q, mq_d;      // Booth Q register (multiplier)
  logic                 qm1_q, qm1_d;
  logic [IDW-1:0]       id_q, id_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [IDW-1:0]       rid_q, rid_d;

  logic [WIDTH-1:0]     a_arr [NREQ];
  logic [WIDTH-1:0]     b_arr [NREQ];
  logic [WIDTH-1:0]     a_sel, b_sel;
  logic                 lo_found, hi_found, grant_found, accept;
  logic [IDW-1:0]       lo_id, hi_id, grant_id;
  logic [WIDTH:0]       sum;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
      assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Round-robin grant: lowest valid index at or above rr_ptr, otherwise the
  // lowest valid index overall (the wrap-around case). Scanning downward lets
  // the last hit be the lowest index.
  always_comb begin
    lo_found = 1'b0;
    lo_id    = '0;
    hi_found = 1'b0;
    hi_id    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_found = 1'b1;
        lo_id    = IDW'(i);
        if (IDW'(i) >= rr_ptr_q) begin
          hi_found = 1'b1;
          hi_id    = IDW'(i);
        end
      end
    end
    grant_found = lo_found;
    grant_id    = hi_found ? hi_id : lo_id;
  end

  assign accept = (state_q == IDLE) && grant_found;
  assign a_sel  = a_arr[grant_id];
  assign b_sel  = b_arr[grant_id];

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    m_d      = m_q;
    acc_d    = acc_q;
    mq_d     = mq_q;
    qm1_d    = qm1_q;
    id_d     = id_q;
    count_d  = count_q;
    prod_d   = prod_q;
    rid_d    = rid_q;
    sum      = acc_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          m_d      = {a_sel[WIDTH-1], a_sel};
          acc_d    = '0;
          mq_d     = b_sel;
          qm1_d    = 1'b0;
          id_d     = grant_id;
          count_d  = '0;
          rr_ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
          state_d  = RUN;
`ifdef BOOTH_ZERO_BYPASS_EN
          if (a_sel == '0 || b_sel == '0) begin
            prod_d  = '0;
            rid_d   = grant_id;
            state_d = DONE;
          end
`endif
        end
      end
      RUN: begin
        case ({mq_q[0], qm1_q})
          2'b01:   sum = acc_q + m_q;
          2'b10:   sum = acc_q - m_q;
          default: sum = acc_q;
        endcase
        // Arithmetic shift right of {A, Q, q_m1}
        acc_d   = {sum[WIDTH], sum[WIDTH:1]};
        mq_d    = {sum[0], mq_q[WIDTH-1:1]};
        qm1_d   = mq_q[0];
        count_d = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) begin
          prod_d  = {acc_d[WIDTH-1:0], mq_d};
          rid_d   = id_q;
          state_d = DONE;
        end
      end
      DONE: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      m_q      <= '0;
      acc_q    <= '0;
      mq_q     <= '0;
      qm1_q    <= 1'b0;
      id_q     <= '0;
      count_q  <= '0;
      prod_q   <= '0;
      rid_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      mq_q     <= mq_d;
      qm1_q    <= qm1_d;
      id_q     <= id_d;
      count_q  <= count_d;
      prod_q   <= prod_d;
      rid_q    <= rid_d;
    end
  end

  assign resp_valid   = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign resp_product = prod_q;
  assign resp_id      = rid_q;

endmodule

// File: tb/tb_booth_mult_sched.sv
// Testbench for booth_mult_sched (WIDTH=4, NREQ=2).
// The driver side feeds per-requester job queues and pushes the expected
// {id, product, latency} into a scoreboard when a job is accepted. The monitor
// runs on the falling edge and performs all checks. It pops the scoreboard on
// each consumed response and checks the arbitration, busy, hold stability and
// reset outputs against a round-robin model.
module tb_booth_mult_sched;
  localparam int W    = 4;
  localparam int NREQ = 2;
  localparam int IDW  = 1;
  localparam int PW   = 2 * W;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [PW-1:0]     resp_product;
  logic              busy;

  booth_mult_sched #(.WIDTH(W), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_product(resp_product),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic signed [W-1:0] a; logic signed [W-1:0] b; } job_t;
  typedef struct { int id; logic [PW-1:0] prod; int acc; int lat; } exp_t;

  job_t jq0[$];
  job_t jq1[$];
  exp_t sb[$];

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int timeouts = 0;
  int acc_total = 0;
  bit rand_en = 0, rand_rdy = 0, bp_hold = 0;
  bit final_req = 0, final_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- driver side ----------------
  task automatic add_job(input int r, input int a, input int b);
    job_t j;
    j.a = W'(a);
    j.b = W'(b);
    if (r == 0) jq0.push_back(j); else jq1.push_back(j);
  endtask

  task automatic drive_inputs();
    logic v0, v1;
    v0 = (jq0.size() > 0) && (!rand_en || $urandom_range(0, 3) != 0);
    v1 = (jq1.size() > 0) && (!rand_en || $urandom_range(0, 3) != 0);
    req_valid = {v1, v0};
    req_a[0 +: W] = (jq0.size() > 0) ? jq0[0].a : W'($urandom);
    req_b[0 +: W] = (jq0.size() > 0) ? jq0[0].b : W'($urandom);
    req_a[W +: W] = (jq1.size() > 0) ? jq1[0].a : W'($urandom);
    req_b[W +: W] = (jq1.size() > 0) ? jq1[0].b : W'($urandom);
    resp_ready = bp_hold ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
  endtask

  task automatic step();
    job_t j;
    exp_t e;
    int   g, pa, pb;
    @(negedge clk);
    if (!rst && (req_valid & req_ready) != '0) begin
      g = (req_valid[0] & req_ready[0]) ? 0 : 1;
      if (g == 0) j = jq0.pop_front(); else j = jq1.pop_front();
      pa = j.a;
      pb = j.b;
      e.id   = g;
      e.prod = PW'(pa * pb);
      e.acc  = cyc + 1;
      e.lat  = W;
`ifdef BOOTH_ZERO_BYPASS_EN
      if (pa == 0 || pb == 0) e.lat = 1;
`endif
      sb.push_back(e);
      acc_total++;
    end
    @(posedge clk);
    #1;
    drive_inputs();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((jq0.size() > 0 || jq1.size() > 0 || sb.size() > 0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) timeouts++;
  endtask

  // ---------------- monitor / checker ----------------
  int            mrr = 0;
  bit            outst = 0;
  bit            prev_valid = 0;
  bit            rst_prev = 0;
  logic [PW-1:0] held_prod = '0;
  int            held_id = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [NREQ-1:0] exp_r;
    logic [NREQ-1:0] fire;
    exp_t e;
    int idx;
    if (rst) begin
      sb.delete();
      mrr        = 0;
      outst      = 0;
      prev_valid = 0;
      rst_prev   = 1;
    end else begin
      if (rst_prev) begin
        chk("reset_busy", int'(busy), 0);
        chk("reset_resp_valid", int'(resp_valid), 0);
        chk("reset_resp_id", int'(resp_id), 0);
        chk("reset_resp_product", int'(resp_product), 0);
        rst_prev = 0;
      end
      exp_r = '0;
      if (!outst && req_valid != '0) begin
        for (int k = NREQ - 1; k >= 0; k--) begin
          idx = (mrr + k) % NREQ;
          if (req_valid[idx]) exp_r = NREQ'(1) << idx;
        end
      end
      chk("req_ready", int'(req_ready), int'(exp_r));
      chk("busy", int'(busy), int'(outst));
      if (resp_valid) begin
        if (!prev_valid) begin
          chk("resp_has_job", int'(sb.size() > 0), 1);
          if (sb.size() > 0) chk("latency", cyc - sb[0].acc, sb[0].lat);
        end else begin
          chk("hold_product", int'(resp_product), int'(held_prod));
          chk("hold_id", int'(resp_id), held_id);
        end
        held_prod = resp_product;
        held_id   = int'(resp_id);
        if (resp_ready) begin
          if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("resp_id", int'(resp_id), e.id);
            chk("resp_product", int'(resp_product), int'(e.prod));
            $display("[TB] resp id=%0d product=%h expected id=%0d product=%h",
                     resp_id, resp_product, e.id, e.prod);
          end
          outst = 0;
        end
      end
      prev_valid = resp_valid && !resp_ready;
      fire = req_valid & req_ready;
      if (fire != '0) begin
        idx = fire[0] ? 0 : 1;
        mrr = (idx + 1) % NREQ;
        outst = 1;
      end
    end
    if (final_req && !final_done) begin
      chk("drain_timeouts", timeouts, 0);
      chk("scoreboard_empty", sb.size(), 0);
      final_done = 1;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int start, n;
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    drive_inputs();

    // Basic product on requester 0
    add_job(0, 3, 1);
    drain(50);

    // Sign cases on requester 1, including the most-negative multiplicand
    add_job(1, -6, 7);
    add_job(1, -2, -5);
    add_job(1, -5, -5);
    add_job(1, -8, -8);
    add_job(1, -8, 7);
    drain(200);

    // Zero operands (bypass latency when enabled)
    add_job(0, 0, -3);
    add_job(1, 5, 0);
    drain(100);

    // Arbitration: both requesters continuously valid
    for (int i = 0; i < 4; i++) begin
      add_job(0, $urandom_range(0, 15), $urandom_range(0, 15));
      add_job(1, $urandom_range(0, 15), $urandom_range(0, 15));
    end
    drain(200);

    // Backpressure: hold resp_ready low for 10 cycles in DONE
    bp_hold = 1;
    add_job(0, -7, 5);
    add_job(1, 6, -3);
    n = 0;
    while (!resp_valid && n < 30) begin
      step();
      n++;
    end
    if (n >= 30) timeouts++;
    repeat (10) step();
    bp_hold = 0;
    drain(100);

    // Reset while RUN has count==2
    add_job(0, 7, 7);
    add_job(0, -3, 2);
    add_job(1, 4, -4);
    add_job(1, -1, -1);
    start = acc_total;
    n = 0;
    while (acc_total == start && n < 30) begin
      step();
      n++;
    end
    if (n >= 30) timeouts++;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    drain(200);

    // Randomized traffic with random valids and backpressure
    rand_en  = 1;
    rand_rdy = 1;
    for (int i = 0; i < 40; i++) begin
      add_job($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 15));
    end
    drain(3000);
    rand_en  = 0;
    rand_rdy = 0;

    final_req = 1;
    step();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
